// File: rtl/ssd_scan_decoder_if.sv
// rtl/ssd_scan_decoder_if.sv - scan bus and decoded-result bundle for the seven-segment scan decoder
// The master side drives the anode/cathode bus; the slave side is the decoder.
interface ssd_scan_decoder_if #(
    parameter int FRAME_CNT_W = 8
);
    logic [3:0]             an;
    logic [6:0]             seg;
    logic [3:0]             digit3;
    logic [3:0]             digit2;
    logic [3:0]             digit1;
    logic [3:0]             digit0;
    logic                   frame_valid;
    logic                   seg_error;
    logic                   order_error;
    logic [FRAME_CNT_W-1:0] frame_count;

    modport master (
        output an,
        output seg,
        input  digit3,
        input  digit2,
        input  digit1,
        input  digit0,
        input  frame_valid,
        input  seg_error,
        input  order_error,
        input  frame_count
    );

    modport slave (
        input  an,
        input  seg,
        output digit3,
        output digit2,
        output digit1,
        output digit0,
        output frame_valid,
        output seg_error,
        output order_error,
        output frame_count
    );
endinterface

// File: rtl/ssd_scan_decoder.sv
// rtl/ssd_scan_decoder.sv - rebuilds four BCD digits from a multiplexed seven-segment scan bus
// Captures each anode once it has been stable, checks AN3..AN0 ordering and publishes whole frames.
module ssd_scan_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    ssd_scan_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        EXP2 = 2'd1,
        EXP1 = 2'd2,
        EXP0 = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_HIT = 8'(SETTLE_CYCLES - 1);

    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = {1'b0, 4'd0};
            7'b1001111: r = {1'b0, 4'd1};
            7'b0010010: r = {1'b0, 4'd2};
            7'b0000110: r = {1'b0, 4'd3};
            7'b1001100: r = {1'b0, 4'd4};
            7'b0100100: r = {1'b0, 4'd5};
            7'b0100000: r = {1'b0, 4'd6};
            7'b0001111: r = {1'b0, 4'd7};
            7'b0000000: r = {1'b0, 4'd8};
            7'b0000100: r = {1'b0, 4'd9};
            7'b1111111: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    logic [3:0]             an_s1_q, an_s1_d;
    logic [3:0]             an_s2_q, an_s2_d;
    logic [6:0]             seg_s1_q, seg_s1_d;
    logic [6:0]             seg_s2_q, seg_s2_d;
    logic [3:0]             an_prev_q, an_prev_d;
    logic [7:0]             settle_q, settle_d;
    state_t                 state_q, state_d;
    logic [3:0]             shadow3_q, shadow3_d;
    logic [3:0]             shadow2_q, shadow2_d;
    logic [3:0]             shadow1_q, shadow1_d;
    logic [3:0]             digit3_q, digit3_d;
    logic [3:0]             digit2_q, digit2_d;
    logic [3:0]             digit1_q, digit1_d;
    logic [3:0]             digit0_q, digit0_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   seg_error_q, seg_error_d;
    logic                   order_error_q, order_error_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    logic       an_change;
    logic       capture;
    logic       an_blank;
    logic       an_legal;
    logic [1:0] an_sel;
    logic [1:0] exp_sel;
    logic [4:0] decoded;
    logic       dec_err;
    logic [3:0] dec_bcd;

    always_comb begin
        an_s1_d  = bus.an;
        an_s2_d  = an_s1_q;
        seg_s1_d = bus.seg;
        seg_s2_d = seg_s1_q;
        an_prev_d = an_s2_q;
    end

    // Capture fires only on the transition into SETTLE_HIT, so a held digit is sampled once.
    always_comb begin
        an_change = (an_s2_q != an_prev_q);
        if (an_change) begin
            settle_d = 8'd0;
        end else if (settle_q == SETTLE_MAX) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 8'd1;
        end
        capture = (settle_d == SETTLE_HIT) && (an_change || (settle_q != SETTLE_HIT));
    end

    always_comb begin
        an_blank = 1'b0;
        an_legal = 1'b1;
        an_sel   = 2'd0;
        case (an_s2_q)
            4'b1110: an_sel   = 2'd0;
            4'b1101: an_sel   = 2'd1;
            4'b1011: an_sel   = 2'd2;
            4'b0111: an_sel   = 2'd3;
            4'b1111: an_blank = 1'b1;
            default: an_legal = 1'b0;
        endcase
    end

    always_comb begin
        decoded = decode_seg(seg_s2_q);
        dec_err = decoded[4];
        dec_bcd = decoded[3:0];
        case (state_q)
            EXP2:    exp_sel = 2'd2;
            EXP1:    exp_sel = 2'd1;
            default: exp_sel = 2'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        shadow3_d     = shadow3_q;
        shadow2_d     = shadow2_q;
        shadow1_d     = shadow1_q;
        digit3_d      = digit3_q;
        digit2_d      = digit2_q;
        digit1_d      = digit1_q;
        digit0_d      = digit0_q;
        frame_valid_d = 1'b0;
        seg_error_d   = 1'b0;
        order_error_d = 1'b0;
        frame_count_d = frame_count_q;

        if (capture && !an_blank) begin
            if (!an_legal) begin
                order_error_d = 1'b1;
                state_d       = HUNT;
                shadow3_d     = 4'hF;
                shadow2_d     = 4'hF;
                shadow1_d     = 4'hF;
            end else if (an_sel == 2'd3) begin
                // AN3 always starts a new frame; mid-frame it is a restart and flagged.
                shadow3_d = dec_bcd;
                shadow2_d = 4'hF;
                shadow1_d = 4'hF;
                state_d   = EXP2;
                if (state_q != HUNT) begin
                    order_error_d = 1'b1;
                end else begin
                    seg_error_d = dec_err;
                end
            end else if (state_q != HUNT) begin
                if (an_sel == exp_sel) begin
                    seg_error_d = dec_err;
                    case (state_q)
                        EXP2: begin
                            shadow2_d = dec_bcd;
                            state_d   = EXP1;
                        end
                        EXP1: begin
                            shadow1_d = dec_bcd;
                            state_d   = EXP0;
                        end
                        default: begin
                            digit3_d      = shadow3_q;
                            digit2_d      = shadow2_q;
                            digit1_d      = shadow1_q;
                            digit0_d      = dec_bcd;
                            frame_valid_d = 1'b1;
                            frame_count_d = frame_count_q + FRAME_CNT_W'(1);
                            state_d       = HUNT;
                            shadow3_d     = 4'hF;
                            shadow2_d     = 4'hF;
                            shadow1_d     = 4'hF;
                        end
                    endcase
                end else begin
                    order_error_d = 1'b1;
                    state_d       = HUNT;
                    shadow3_d     = 4'hF;
                    shadow2_d     = 4'hF;
                    shadow1_d     = 4'hF;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            an_s1_q       <= 4'b1111;
            an_s2_q       <= 4'b1111;
            seg_s1_q      <= 7'b1111111;
            seg_s2_q      <= 7'b1111111;
            an_prev_q     <= 4'b1111;
            settle_q      <= 8'd0;
            state_q       <= HUNT;
            shadow3_q     <= 4'hF;
            shadow2_q     <= 4'hF;
            shadow1_q     <= 4'hF;
            digit3_q      <= 4'hF;
            digit2_q      <= 4'hF;
            digit1_q      <= 4'hF;
            digit0_q      <= 4'hF;
            frame_valid_q <= 1'b0;
            seg_error_q   <= 1'b0;
            order_error_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            an_s1_q       <= an_s1_d;
            an_s2_q       <= an_s2_d;
            seg_s1_q      <= seg_s1_d;
            seg_s2_q      <= seg_s2_d;
            an_prev_q     <= an_prev_d;
            settle_q      <= settle_d;
            state_q       <= state_d;
            shadow3_q     <= shadow3_d;
            shadow2_q     <= shadow2_d;
            shadow1_q     <= shadow1_d;
            digit3_q      <= digit3_d;
            digit2_q      <= digit2_d;
            digit1_q      <= digit1_d;
            digit0_q      <= digit0_d;
            frame_valid_q <= frame_valid_d;
            seg_error_q   <= seg_error_d;
            order_error_q <= order_error_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.digit3      = digit3_q;
    assign bus.digit2      = digit2_q;
    assign bus.digit1      = digit1_q;
    assign bus.digit0      = digit0_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.seg_error   = seg_error_q;
    assign bus.order_error = order_error_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb/tb_ssd_scan_decoder.sv - scoreboard bench for the seven-segment scan decoder
module tb_ssd_scan_decoder;

    localparam int SETTLE = 4;
    localparam int FCW    = 8;
    localparam int LAT    = SETTLE + 2;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [3:0] A3    = 4'b0111;
    localparam logic [3:0] A2    = 4'b1011;
    localparam logic [3:0] A1    = 4'b1101;
    localparam logic [3:0] A0    = 4'b1110;
    localparam logic [3:0] AOFF  = 4'b1111;

    typedef struct {
        logic [15:0]    digs;
        logic [FCW-1:0] fc;
        int             cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    exp_t           sb[$];
    int             n_cmp = 0;
    int             n_fail = 0;
    int             cyc = 0;
    int             n_fv = 0;
    int             n_se = 0;
    int             n_oe = 0;
    logic [FCW-1:0] exp_fc = '0;
    logic [6:0]     enc [0:9];

    always #5 clock = ~clock;

    ssd_scan_decoder_if #(.FRAME_CNT_W(FCW)) bus ();

    ssd_scan_decoder #(
        .SETTLE_CYCLES(SETTLE),
        .FRAME_CNT_W  (FCW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (bus.seg_error === 1'b1) n_se = n_se + 1;
        if (bus.order_error === 1'b1) n_oe = n_oe + 1;
        if (bus.frame_valid === 1'b1) begin
            n_fv  = n_fv + 1;
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL frame_unexpected: frame_valid with digits %h count %0d, required no frame",
                         {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, bus.frame_count);
            end else begin
                e = sb.pop_front();
                if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== e.digs ||
                    bus.frame_count !== e.fc || cyc != e.cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL frame_content: got digits %h count %0d cycle %0d, required digits %h count %0d cycle %0d",
                             {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, bus.frame_count, cyc,
                             e.digs, e.fc, e.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n,
                        input bit push, input logic [15:0] digs);
        exp_t e;
        @(negedge clock);
        bus.an  = a;
        bus.seg = s;
        if (push) begin
            exp_fc = exp_fc + FCW'(1);
            e.digs = digs;
            e.fc   = exp_fc;
            e.cyc  = cyc + LAT;
            sb.push_back(e);
        end
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic scan(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                        input logic [6:0] s0, input logic [15:0] digs, input int hold);
        show(A3, s3, hold, 1'b0, 16'h0);
        show(A2, s2, hold, 1'b0, 16'h0);
        show(A1, s1, hold, 1'b0, 16'h0);
        show(A0, s0, hold, 1'b1, digs);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset  = 1'b0;
        exp_fc = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        bus.an  = AOFF;
        bus.seg = BLANK;
        do_reset(3);
        n_cmp = n_cmp + 5;
        if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== 16'hFFFF) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_digits: got %h, required ffff", {bus.digit3, bus.digit2, bus.digit1, bus.digit0});
        end
        if (bus.frame_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_frame_valid: got %b, required 0", bus.frame_valid);
        end
        if (bus.seg_error !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_seg_error: got %b, required 0", bus.seg_error);
        end
        if (bus.order_error !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_order_error: got %b, required 0", bus.order_error);
        end
        if (bus.frame_count !== 8'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_frame_count: got %0d, required 0", bus.frame_count);
        end
    endtask

    task automatic test_basic_scan();
        int fv0, se0, oe0;
        fv0 = n_fv; se0 = n_se; oe0 = n_oe;
        scan(BLANK, BLANK, enc[5], enc[9], 16'hFF59, 8);
        show(AOFF, BLANK, 8, 1'b0, 16'h0);
        n_cmp = n_cmp + 4;
        if (n_fv - fv0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL basic_frame_pulses: got %0d, required 1", n_fv - fv0);
        end
        if (n_se - se0 != 0 || n_oe - oe0 != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL basic_errors: got seg %0d order %0d, required 0 0", n_se - se0, n_oe - oe0);
        end
        if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== 16'hFF59) begin
            n_fail = n_fail + 1;
            $display("FAIL basic_digits_hold: got %h, required ff59", {bus.digit3, bus.digit2, bus.digit1, bus.digit0});
        end
        if (bus.frame_count !== 8'd1) begin
            n_fail = n_fail + 1;
            $display("FAIL basic_frame_count: got %0d, required 1", bus.frame_count);
        end
    endtask

    task automatic test_glitch();
        int fv0;
        fv0 = n_fv;
        show(A3, BLANK, 8, 1'b0, 16'h0);
        show(A2, BLANK, 8, 1'b0, 16'h0);
        show(A1, enc[1], 2, 1'b0, 16'h0);
        show(A1, enc[5], 6, 1'b0, 16'h0);
        show(A0, enc[9], 8, 1'b1, 16'hFF59);
        show(AOFF, BLANK, 8, 1'b0, 16'h0);
        n_cmp = n_cmp + 2;
        if (n_fv - fv0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL glitch_frame_pulses: got %0d, required 1", n_fv - fv0);
        end
        if (bus.digit1 !== 4'd5) begin
            n_fail = n_fail + 1;
            $display("FAIL glitch_digit1: got %h, required 5", bus.digit1);
        end
    endtask

    task automatic test_order_skip();
        int fv0, oe0;
        fv0 = n_fv; oe0 = n_oe;
        show(A3, enc[3], 8, 1'b0, 16'h0);
        show(A1, enc[1], 8, 1'b0, 16'h0);
        show(AOFF, BLANK, 8, 1'b0, 16'h0);
        n_cmp = n_cmp + 3;
        if (n_oe - oe0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL skip_order_error: got %0d pulses, required 1", n_oe - oe0);
        end
        if (n_fv - fv0 != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL skip_no_frame: got %0d frames, required 0", n_fv - fv0);
        end
        if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== 16'hFF59) begin
            n_fail = n_fail + 1;
            $display("FAIL skip_digits_kept: got %h, required ff59", {bus.digit3, bus.digit2, bus.digit1, bus.digit0});
        end
        scan(enc[1], enc[2], enc[3], enc[4], 16'h1234, 8);
        show(AOFF, BLANK, 8, 1'b0, 16'h0);
        n_cmp = n_cmp + 2;
        if (n_fv - fv0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL skip_recover_frame: got %0d frames, required 1", n_fv - fv0);
        end
        if (n_oe - oe0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL skip_recover_errors: got %0d order pulses, required 1", n_oe - oe0);
        end
    endtask

    task automatic test_seg_error();
        int fv0, se0, oe0;
        fv0 = n_fv; se0 = n_se; oe0 = n_oe;
        scan(enc[8], enc[7], enc[6], 7'b0110000, 16'h876E, 8);
        show(AOFF, BLANK, 8, 1'b0, 16'h0);
        n_cmp = n_cmp + 4;
        if (n_se - se0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL segerr_pulse: got %0d, required 1", n_se - se0);
        end
        if (n_oe - oe0 != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL segerr_no_order: got %0d, required 0", n_oe - oe0);
        end
        if (n_fv - fv0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL segerr_frame: got %0d frames, required 1", n_fv - fv0);
        end
        if (bus.digit0 !== 4'hE) begin
            n_fail = n_fail + 1;
            $display("FAIL segerr_digit0: got %h, required e", bus.digit0);
        end
    endtask

    task automatic test_illegal_and_blank();
        int fv0, se0, oe0;
        fv0 = n_fv; se0 = n_se; oe0 = n_oe;
        show(A3, enc[2], 8, 1'b0, 16'h0);
        show(A2, enc[2], 8, 1'b0, 16'h0);
        show(4'b0011, enc[0], 8, 1'b0, 16'h0);
        show(AOFF, BLANK, 8, 1'b0, 16'h0);
        n_cmp = n_cmp + 2;
        if (n_oe - oe0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL illegal_order_error: got %0d, required 1", n_oe - oe0);
        end
        if (n_fv - fv0 != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL illegal_no_frame: got %0d frames, required 0", n_fv - fv0);
        end
        oe0 = n_oe;
        show(A3, enc[0], 8, 1'b0, 16'h0);
        show(AOFF, BLANK, 4, 1'b0, 16'h0);
        show(A2, enc[6], 8, 1'b0, 16'h0);
        show(AOFF, BLANK, 4, 1'b0, 16'h0);
        show(A1, enc[4], 8, 1'b0, 16'h0);
        show(AOFF, BLANK, 4, 1'b0, 16'h0);
        show(A0, enc[7], 8, 1'b1, 16'h0647);
        show(AOFF, BLANK, 8, 1'b0, 16'h0);
        n_cmp = n_cmp + 3;
        if (n_oe - oe0 != 0 || n_se - se0 != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL gaps_no_errors: got order %0d seg %0d, required 0 0", n_oe - oe0, n_se - se0);
        end
        if (n_fv - fv0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL gaps_frame: got %0d frames, required 1", n_fv - fv0);
        end
        if (bus.frame_count !== 8'd5) begin
            n_fail = n_fail + 1;
            $display("FAIL gaps_frame_count: got %0d, required 5", bus.frame_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fv0, oe0;
        show(A3, enc[9], 8, 1'b0, 16'h0);
        show(A2, enc[9], 8, 1'b0, 16'h0);
        do_reset(1);
        n_cmp = n_cmp + 2;
        if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== 16'hFFFF) begin
            n_fail = n_fail + 1;
            $display("FAIL midreset_digits: got %h, required ffff", {bus.digit3, bus.digit2, bus.digit1, bus.digit0});
        end
        if (bus.frame_count !== 8'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL midreset_frame_count: got %0d, required 0", bus.frame_count);
        end
        fv0 = n_fv; oe0 = n_oe;
        show(A1, enc[9], 8, 1'b0, 16'h0);
        show(A0, enc[9], 8, 1'b0, 16'h0);
        show(AOFF, BLANK, 8, 1'b0, 16'h0);
        n_cmp = n_cmp + 3;
        if (n_fv - fv0 != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL midreset_no_frame: got %0d frames, required 0", n_fv - fv0);
        end
        if (n_oe - oe0 != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL midreset_no_order: got %0d, required 0", n_oe - oe0);
        end
        if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== 16'hFFFF) begin
            n_fail = n_fail + 1;
            $display("FAIL midreset_digits_after: got %h, required ffff", {bus.digit3, bus.digit2, bus.digit1, bus.digit0});
        end
    endtask

    task automatic test_back_to_back();
        int fv0, se0, oe0;
        logic [3:0] d3, d2, d1, d0;
        fv0 = n_fv; se0 = n_se; oe0 = n_oe;
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
        for (int i = 0; i < 256; i++) begin
            d3 = 4'(i % 10);
            d2 = 4'((i / 10) % 10);
            d1 = 4'((i + 3) % 10);
            d0 = 4'((7 * i) % 10);
            scan(enc[d3], enc[d2], enc[d1], enc[d0], {d3, d2, d1, d0}, 6);
        end
        show(AOFF, BLANK, 10, 1'b0, 16'h0);
        n_cmp = n_cmp + 4;
        if (n_fv - fv0 != 256) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_frames: got %0d, required 256", n_fv - fv0);
        end
        if (bus.frame_count !== 8'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_wrap: got %0d, required 0", bus.frame_count);
        end
        if (n_se - se0 != 0 || n_oe - oe0 != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_errors: got seg %0d order %0d, required 0 0", n_se - se0, n_oe - oe0);
        end
        if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== {d3, d2, d1, d0}) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_last_digits: got %h, required %h",
                     {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, {d3, d2, d1, d0});
        end
    endtask

    initial begin
        enc[0] = 7'b0000001; enc[1] = 7'b1001111; enc[2] = 7'b0010010; enc[3] = 7'b0000110;
        enc[4] = 7'b1001100; enc[5] = 7'b0100100; enc[6] = 7'b0100000; enc[7] = 7'b0001111;
        enc[8] = 7'b0000000; enc[9] = 7'b0000100;
        bus.an  = AOFF;
        bus.seg = BLANK;

        test_reset();
        test_basic_scan();
        test_glitch();
        test_order_skip();
        test_seg_error();
        test_illegal_and_blank();
        test_reset_mid_frame();
        test_back_to_back();

        repeat (20) @(negedge clock);
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: got %0d frames outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
